// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/pipeline sequencer.
// The ID-stage decoder and the EX stage import the same encodings.
package hazard_ctrl_pkg;

    // Sequencer states
    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MDU_WAIT = 1'b1
    } hz_state_e;

    // ALUOp codes that select the multi-cycle mult/div unit
    localparam logic [3:0] ALUOP_MULT  = 4'b1000;
    localparam logic [3:0] ALUOP_MULTU = 4'b1001;
    localparam logic [3:0] ALUOP_DIV   = 4'b1010;
    localparam logic [3:0] ALUOP_DIVU  = 4'b1011;

    // Position of the memory-read bit inside the ID/EX M control field
    localparam int IDEX_M_MEMRD_BIT = 1;

    // Load-use: a load in EX writes a register the instruction in ID reads.
    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic lu_match(
        input logic       mem_rd,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_rd && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter used for the hazard performance counters.
// Only present when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count up on inc, stick at all-ones, clear on reset (active-low)
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for PC, IF/ID and ID/EX: load-use stall, branch flush,
// and front-of-pipe hold while a multi-cycle mult/div occupies EX.
// Optional stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_MemRd,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_mdu,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             branch_taken,
    output logic             PCWr,
    output logic             IFIDWr,
    output logic             IFIDrst,
    output logic             IDEXWr,
    output logic             IDEXrst,
    output logic             mdu_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_lu,
    output logic [CNT_W-1:0] perf_mdu,
    output logic [CNT_W-1:0] perf_fl
`endif
);

    // The op sits in EX for the entry cycle plus MDU_LAT-1 wait cycles;
    // the last wait cycle (cnt==0) is the release cycle.
    localparam int                 CNT_BITS = $clog2(MDU_LAT);
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MDU_LAT - 2);

    hz_state_e           state_reg, state_next;
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;

    logic in_reset;
    logic lu_hit;
    logic hold;
    logic lu_stall;
    logic br_flush;

    assign in_reset = !rst;
    assign lu_hit   = lu_match(IDEX_MemRd, IDEX_Rt, IFID_Rs, IFID_Rt);

    // State and down-counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= HZ_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and hazard classification; priority mdu > load-use > branch
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hold       = 1'b0;
        lu_stall   = 1'b0;
        br_flush   = 1'b0;

        if (!in_reset) begin
            logic run_rules;
            run_rules = 1'b0;
            unique case (state_reg)
                HZ_RUN: begin
                    if (IDEX_mdu) begin
                        hold       = 1'b1;
                        state_next = HZ_MDU_WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        run_rules = 1'b1;
                    end
                end
                HZ_MDU_WAIT: begin
                    if (cnt_reg != '0) begin
                        hold     = 1'b1;
                        cnt_next = cnt_reg - CNT_BITS'(1);
                    end else begin
                        // Release cycle behaves like RUN; IDEX_mdu still refers
                        // to the finishing op, so it is not looked at here.
                        run_rules  = 1'b1;
                        state_next = HZ_RUN;
                    end
                end
                default: begin
                    state_next = HZ_RUN;
                    cnt_next   = '0;
                end
            endcase

            // A branch under a load-use stall is retried next cycle with the
            // same IF/ID content, so it is simply not acted on here.
            if (run_rules) begin
                if (lu_hit) begin
                    lu_stall = 1'b1;
                end else if (branch_taken) begin
                    br_flush = 1'b1;
                end
            end
        end
    end

    // Output decode; reset parks every stage register and bubbles both
    assign PCWr     = !(in_reset || hold || lu_stall);
    assign IFIDWr   = !(in_reset || hold || lu_stall);
    assign IFIDrst  = in_reset || br_flush;
    assign IDEXWr   = !(in_reset || hold);
    assign IDEXrst  = in_reset || lu_stall;
    assign mdu_busy = hold;

`ifdef HAZARD_PERF_CNT_EN
    // Index 0: load-use stalls, 1: mult/div busy cycles, 2: branch flushes
    logic [2:0]       perf_inc;
    logic [CNT_W-1:0] perf_val [3];

    assign perf_inc = {br_flush, hold, lu_stall};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            hazard_sat_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (perf_inc[gi]),
                .count (perf_val[gi])
            );
        end
    endgenerate

    assign perf_lu  = perf_val[0];
    assign perf_mdu = perf_val[1];
    assign perf_fl  = perf_val[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MDU_LAT=4 and MDU_LAT=2)
// share the same directed stimulus; a monitor compares both each cycle.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       IDEX_MemRd = 1'b0;
    logic [4:0] IDEX_Rt = 5'd0;
    logic       IDEX_mdu = 1'b0;
    logic [4:0] IFID_Rs = 5'd0;
    logic [4:0] IFID_Rt = 5'd0;
    logic       branch_taken = 1'b0;

    logic pc4, ifw4, ifr4, idw4, idr4, busy4;
    logic pc2, ifw2, ifr2, idw2, idr2, busy2;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] plu4, pmdu4, pfl4, plu2, pmdu2, pfl2;
`endif

    hazard_ctrl #(
        .MDU_LAT (4)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W (4)
`endif
    ) dut4 (
        .clk (clk), .rst (rst),
        .IDEX_MemRd (IDEX_MemRd), .IDEX_Rt (IDEX_Rt), .IDEX_mdu (IDEX_mdu),
        .IFID_Rs (IFID_Rs), .IFID_Rt (IFID_Rt), .branch_taken (branch_taken),
        .PCWr (pc4), .IFIDWr (ifw4), .IFIDrst (ifr4),
        .IDEXWr (idw4), .IDEXrst (idr4), .mdu_busy (busy4)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu (plu4), .perf_mdu (pmdu4), .perf_fl (pfl4)
`endif
    );

    hazard_ctrl #(
        .MDU_LAT (2)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W (4)
`endif
    ) dut2 (
        .clk (clk), .rst (rst),
        .IDEX_MemRd (IDEX_MemRd), .IDEX_Rt (IDEX_Rt), .IDEX_mdu (IDEX_mdu),
        .IFID_Rs (IFID_Rs), .IFID_Rt (IFID_Rt), .branch_taken (branch_taken),
        .PCWr (pc2), .IFIDWr (ifw2), .IFIDrst (ifr2),
        .IDEXWr (idw2), .IDEXrst (idr2), .mdu_busy (busy2)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu (plu2), .perf_mdu (pmdu2), .perf_fl (pfl2)
`endif
    );

    // Output vector order: {PCWr, IFIDWr, IFIDrst, IDEXWr, IDEXrst, mdu_busy}
    localparam logic [5:0] O_RST = 6'b001010;
    localparam logic [5:0] O_RUN = 6'b110100;
    localparam logic [5:0] O_STL = 6'b000110;
    localparam logic [5:0] O_FL  = 6'b111100;
    localparam logic [5:0] O_HLD = 6'b000001;

    wire [5:0] got4 = {pc4, ifw4, ifr4, idw4, idr4, busy4};
    wire [5:0] got2 = {pc2, ifw2, ifr2, idw2, idr2, busy2};

    typedef struct {
        string      name;
        logic [5:0] e4;
        logic [5:0] e2;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Drive one cycle of inputs just after the edge and queue the expectation
    task automatic step(input string nm, input logic r, input logic mr,
                        input logic [4:0] rte, input logic md,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic [5:0] e4,
                        input logic [5:0] e2);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        IDEX_MemRd   = mr;
        IDEX_Rt      = rte;
        IDEX_mdu     = md;
        IFID_Rs      = rs;
        IFID_Rt      = rt;
        branch_taken = br;
        e.name = nm;
        e.e4   = e4;
        e.e2   = e2;
        sb.push_back(e);
    endtask

    // Monitor: pop and compare on the falling edge, away from the update edge
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (got4 !== e.e4) begin
                    failures++;
                    $display("FAIL %s lat4 got=%b want=%b", e.name, got4, e.e4);
                end
                checks++;
                if (got2 !== e.e2) begin
                    failures++;
                    $display("FAIL %s lat2 got=%b want=%b", e.name, got2, e.e2);
                end
                $display("txn %-12s lat4=%b lat2=%b", e.name, got4, got2);
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    task automatic check_perf(input string nm, input logic [3:0] got,
                              input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end else begin
            $display("txn %-12s value=%0d", nm, got);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for three cycles, then released
        for (int i = 0; i < 3; i++)
            step("rst_hold", 0, 0, 0, 0, 0, 0, 0, O_RST, O_RST);
        step("rst_ev",    0, 1, 8, 1, 8, 0, 1, O_RST, O_RST);
        step("rst_rel",   1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);

        // Load-use on Rs, register 0 exclusion, Rt match, no match
        step("lu_rs",     1, 1, 8, 0, 8, 0, 0, O_STL, O_STL);
        step("lu_after",  1, 0, 8, 0, 8, 0, 0, O_RUN, O_RUN);
        step("lu_r0",     1, 1, 0, 0, 0, 0, 0, O_RUN, O_RUN);
        step("lu_rt",     1, 1, 5, 0, 3, 5, 0, O_STL, O_STL);
        step("lu_nomatch",1, 1, 5, 0, 3, 4, 0, O_RUN, O_RUN);

        // Mult/div: lat4 holds 3 cycles, lat2 holds 1
        step("mdu",       1, 0, 0, 1, 0, 0, 0, O_HLD, O_HLD);
        step("mdu_w1",    1, 0, 0, 0, 0, 0, 0, O_HLD, O_RUN);
        step("mdu_w2",    1, 0, 0, 0, 0, 0, 0, O_HLD, O_RUN);
        step("mdu_rel",   1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);

        // mdu beats load-use and branch; release cycle obeys RUN rules
        step("mdu_pri",   1, 1, 7, 1, 7, 0, 1, O_HLD, O_HLD);
        step("mdu_w1_br", 1, 0, 0, 0, 0, 0, 1, O_HLD, O_FL);
        step("mdu_w2",    1, 0, 0, 0, 0, 0, 0, O_HLD, O_RUN);
        step("mdu_rel_lu",1, 1, 6, 0, 0, 6, 0, O_STL, O_STL);
        step("idle",      1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);

        // Branch under load-use stalls first, then flushes
        step("br_lu",     1, 1, 9, 0, 0, 9, 1, O_STL, O_STL);
        step("br_retry",  1, 0, 9, 0, 0, 9, 1, O_FL,  O_FL);
        step("br_idle",   1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);

        // Reset on the 2nd cycle the lat4 op is held aborts the wait
        step("mdu5",      1, 0, 0, 1, 0, 0, 0, O_HLD, O_HLD);
        step("mdu5_w1",   1, 0, 0, 0, 0, 0, 0, O_HLD, O_RUN);
        step("mdu5_rst",  0, 0, 0, 0, 0, 0, 0, O_RST, O_RST);
        step("mdu5_after",1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);
        step("mdu5_run",  1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        check_perf("perf_clr4", plu4 | pmdu4 | pfl4, 4'd0);
        step("p_mdu",     1, 0, 0, 1, 0, 0, 0, O_HLD, O_HLD);
        step("p_mdu_w1",  1, 0, 0, 0, 0, 0, 0, O_HLD, O_RUN);
        step("p_mdu_w2",  1, 0, 0, 0, 0, 0, 0, O_HLD, O_RUN);
        step("p_mdu_rel", 1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);
        step("p_idle",    1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);
        @(negedge clk);
        check_perf("perf_mdu4", pmdu4, 4'd3);
        check_perf("perf_mdu2", pmdu2, 4'd1);
        step("p_br",      1, 0, 0, 0, 0, 0, 1, O_FL,  O_FL);
        step("p_idle",    1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);
        @(negedge clk);
        check_perf("perf_fl4",  pfl4, 4'd1);
        for (int i = 0; i < 20; i++) begin
            step("p_lu",   1, 1, 3, 0, 3, 0, 0, O_STL, O_STL);
            step("p_idle", 1, 0, 0, 0, 0, 0, 0, O_RUN, O_RUN);
        end
        @(negedge clk);
        check_perf("perf_lu4",  plu4, 4'd15);
        check_perf("perf_lu2",  plu2, 4'd15);
`endif

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
